// File: rtl/mfp_ahb_arbiter.sv
// Two-master AHB arbiter: M0 is the default master, M1 gets starvation promotion.
// Burst and lock aware, with address-phase and data-phase ownership tracking.
module mfp_ahb_arbiter #(
    parameter int STARVE_LIMIT = 16
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        M0_HBUSREQ,
    input  logic        M1_HBUSREQ,
    input  logic        M0_HLOCK,
    input  logic        M1_HLOCK,
    input  logic [31:0] M0_HADDR,
    input  logic [31:0] M1_HADDR,
    input  logic [1:0]  M0_HTRANS,
    input  logic [1:0]  M1_HTRANS,
    input  logic        M0_HWRITE,
    input  logic        M1_HWRITE,
    input  logic [2:0]  M0_HSIZE,
    input  logic [2:0]  M1_HSIZE,
    input  logic [2:0]  M0_HBURST,
    input  logic [2:0]  M1_HBURST,
    input  logic [3:0]  M0_HPROT,
    input  logic [3:0]  M1_HPROT,
    input  logic [31:0] M0_HWDATA,
    input  logic [31:0] M1_HWDATA,
    input  logic        HREADY,
    output logic        HGRANT0,
    output logic        HGRANT1,
    output logic        HMASTER,
    output logic        HMASTER_D,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic        HMASTLOCK,
    output logic [31:0] HWDATA
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [2:0] BURST_SINGLE = 3'b000;

    typedef enum logic {
        GNT_M0 = 1'b0,
        GNT_M1 = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] starve_cnt;
    logic             promote;
    logic             arb_point;

    // Address-phase signals follow the address owner, write data the data-phase owner.
    assign HADDR     = HMASTER   ? M1_HADDR  : M0_HADDR;
    assign HTRANS    = HMASTER   ? M1_HTRANS : M0_HTRANS;
    assign HWRITE    = HMASTER   ? M1_HWRITE : M0_HWRITE;
    assign HSIZE     = HMASTER   ? M1_HSIZE  : M0_HSIZE;
    assign HBURST    = HMASTER   ? M1_HBURST : M0_HBURST;
    assign HPROT     = HMASTER   ? M1_HPROT  : M0_HPROT;
    assign HMASTLOCK = HMASTER   ? M1_HLOCK  : M0_HLOCK;
    assign HWDATA    = HMASTER_D ? M1_HWDATA : M0_HWDATA;

    assign HGRANT0 = (state == GNT_M0);
    assign HGRANT1 = (state == GNT_M1);

    assign promote = (starve_cnt == CNT_W'(STARVE_LIMIT));

    // SEQ/BUSY or a multi-beat NONSEQ keep the bus so a burst is never split.
    assign arb_point = HREADY && !HMASTLOCK &&
                       ((HTRANS == TRANS_IDLE) ||
                        ((HTRANS == TRANS_NONSEQ) && (HBURST == BURST_SINGLE)));

    always_comb begin
        state_next = state;
        if (arb_point) begin
            if (M1_HBUSREQ && (!M0_HBUSREQ || promote))
                state_next = GNT_M1;
            else
                state_next = GNT_M0;
        end
    end

    // NOTE: non-blocking assignments here so every register samples pre-edge values;
    // HMASTER_D must capture the old HMASTER, not the one loaded on this same edge.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state      <= GNT_M0;
            HMASTER    <= 1'b0;
            HMASTER_D  <= 1'b0;
            starve_cnt <= '0;
        end else begin
            state <= state_next;
            if (HREADY) begin
                HMASTER   <= (state == GNT_M1);
                HMASTER_D <= HMASTER;
            end
            // Counts through wait states too; saturates until M1 is granted.
            if (HGRANT1 || !M1_HBUSREQ)
                starve_cnt <= '0;
            else if (!promote)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule
